peg_l2_mac_pause_parser: RTL and testbench
==========================================

// Module: peg_l2_mac_pause_parser
// PURPOSE
//  RX-side MAC control frame parser. Monitors the receive frame stream from the MAC RX datapath.
//  Detects 802.3x PAUSE frames and extracts the 16-bit pause quanta.
//  Presents the quanta as a one-cycle pulse to the pause counter (pause_time_valid/pause_time),
//  which throttles TX. Only frames that end error-free are reported; also keeps a saturating frame count.
// PARAMETERS
//  BPCLK     64                Bus width in bits; legal values 8/16/32/64 (whole bytes per beat)
//  PAUSE_DA  48'h0180C2000001  Reserved multicast DA accepted for PAUSE
// PORTS
//  clk              in   1      Clock
//  rst              in   1      Synchronous active-high reset
//  pause_en         in   1      Config: 0 = parse but never emit pause_time_valid
//  mac_addr         in   48     Station unicast address; also accepted as DA
//  rx_valid         in   1      Beat qualifier; all rx_* ignored when 0
//  rx_sop           in   1      First beat of frame (byte 0)
//  rx_eop           in   1      Last beat of frame
//  rx_err           in   1      Sampled on the eop beat only: CRC/runt/PHY error
//  rx_data          in   BPCLK  Frame bytes, byte 0 of beat in rx_data[BPCLK-1 -: 8]
//  pause_time_valid out  1      1-cycle pulse: new pause quanta accepted
//  pause_time       out  16     Pause quanta, held until next pulse
//  pause_frm_cnt    out  16     Count of accepted PAUSE frames; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, byte offset 0, capture regs 0.
//   Reset mid-frame discards the frame; no pulse for it.
//  Header (byte offsets): DA 0-5, SA 6-11, EtherType 12-13 = 16'h8808,
//   opcode 14-15 = 16'h0001, quanta 16-17 (big-endian: byte16 = MSB).
//   SA is not checked.
//  byte_off: counts bytes received so far; advances by BPCLK/8 per valid beat;
//   saturates at 18 (5-bit).
//   Each lane compares byte (byte_off+lane) against the expected value for offsets 0-15;
//   lanes beyond offset 17 are don't-care.
//  DA match: all 6 bytes equal PAUSE_DA OR all 6 equal mac_addr.
//   Track both in parallel as match flags.
//  FSM:
//   IDLE  : rx_valid&rx_sop -> HDR (that beat is processed as header data).
//   HDR   : per beat, clear match flags on mismatch; if both DA flags clear
//            or type/opcode mismatch -> DROP.
//           When bytes 16-17 captured and all match -> WAIT (same beat may be eop).
//           rx_eop before byte 17 -> IDLE, no pulse (runt).
//   WAIT  : on rx_valid&rx_eop -> IDLE; if !rx_err emit.
//   DROP  : on rx_valid&rx_eop -> IDLE.
//  Emit: pause_time_valid=1 in the cycle after the eop beat, only if pause_en=1 at that eop beat.
//   In the same cycle, pause_time <= captured quanta.
//   pause_frm_cnt increments regardless of pause_en (error-free PAUSE frames only).
//   Latency eop->pulse = 1 clk.
//   Quanta 16'h0000 is a valid PAUSE (resume) and is emitted.
//  sop in any non-IDLE state: abandon current frame (no pulse) and restart HDR on this beat.
//   sop&eop in one beat (BPCLK=64, <=8 bytes) -> runt, no pulse.
//  rx_valid=0 beats: FSM and byte_off hold.
//   No backpressure; block never stalls the stream.
//  Back-to-back PAUSE frames: each produces its own pulse; the later overwrites pause_time.
// TESTING
//  1. BPCLK=64, pause_en=1: DA 0180C2000001, type 8808, op 0001, quanta 0x1234, 64B, rx_err=0
//     -> pulse 1 clk after eop, pause_time=0x1234, cnt=1.
//  2. Same frame with rx_err=1 on eop -> no pulse, pause_time/cnt unchanged.
//     Same frame with opcode 0x0002 or type 0x0800 -> no pulse.
//  3. DA=mac_addr=0x001122334455, quanta 0xFFFF -> pulse, 0xFFFF.
//     DA=0x001122334456 -> no pulse.
//  4. pause_en=0 on valid PAUSE -> no pulse, cnt increments.
//     Frame truncated by eop at byte 15 -> no pulse.
//     New sop mid-header of a PAUSE frame -> first frame dropped, second frame parsed normally.
//  5. Two PAUSE frames back-to-back (0x0010 then 0x0000), plus idle rx_valid gaps inside the header
//     -> two pulses, final pause_time=0; rst asserted mid-frame -> all outputs 0, no pulse.
//  6. Repeat tests 1 and 3 at BPCLK=8 and 32.
//     Force cnt to 16'hFFFE, send 3 frames -> cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/peg_l2_mac_pause_parser.sv
// peg_l2_mac_pause_parser
// RX-side MAC control frame parser. Watches the receive beat stream, recognises
// 802.3x PAUSE frames (DA = reserved multicast or station address, EtherType
// 8808, opcode 0001), captures the 16-bit pause quanta and reports it as a
// one-cycle pulse after an error-free end of frame. Also keeps a saturating
// count of accepted PAUSE frames.
module peg_l2_mac_pause_parser #(
  parameter int          BPCLK    = 64,
  parameter logic [47:0] PAUSE_DA = 48'h0180C2000001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause_en,
  input  logic [47:0]      mac_addr,
  input  logic             rx_valid,
  input  logic             rx_sop,
  input  logic             rx_eop,
  input  logic             rx_err,
  input  logic [BPCLK-1:0] rx_data,
  output logic             pause_time_valid,
  output logic [15:0]      pause_time,
  output logic [15:0]      pause_frm_cnt
);

  localparam int NB      = BPCLK / 8;
  localparam int OFF_MAX = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  byte_off_q, byte_off_d;
  logic        da_pause_q, da_pause_d;
  logic        da_mac_q, da_mac_d;
  logic [15:0] quanta_q, quanta_d;
  logic        pulse_q;
  logic [15:0] ptime_q;
  logic [15:0] cnt_q;

  logic        emit;
  logic        hdr_bad;
  logic        got_quanta;
  logic        hdr_beat;
  logic [4:0]  base;
  logic [7:0]  lane_byte;
  int          off;

  // Byte offset advance, saturating at the first offset past the quanta.
  function automatic logic [4:0] off_sat_add(input logic [4:0] a);
    int s;
    s = int'(a) + NB;
    if (s > OFF_MAX) s = OFF_MAX;
    return 5'(s);
  endfunction

  // Frame counter increment that sticks at all-ones.
  function automatic logic [15:0] cnt_sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Expected byte for the EtherType/opcode window (offsets 12..15).
  function automatic logic [7:0] hdr_exp(input int o);
    case (o)
      12:      return 8'h88;
      13:      return 8'h08;
      14:      return 8'h00;
      default: return 8'h01;
    endcase
  endfunction

  // Next-state: per-lane header comparison, quanta capture and FSM transitions.
  always_comb begin
    state_d    = state_q;
    byte_off_d = byte_off_q;
    da_pause_d = da_pause_q;
    da_mac_d   = da_mac_q;
    quanta_d   = quanta_q;
    emit       = 1'b0;
    hdr_bad    = 1'b0;
    got_quanta = 1'b0;
    hdr_beat   = 1'b0;
    base       = byte_off_q;
    lane_byte  = 8'h00;
    off        = 0;

    if (rx_valid) begin
      if (rx_sop) begin
        // A sop anywhere restarts header parsing on this very beat.
        hdr_beat   = 1'b1;
        base       = 5'd0;
        da_pause_d = 1'b1;
        da_mac_d   = 1'b1;
        quanta_d   = 16'h0000;
      end else if (state_q == HDR) begin
        hdr_beat = 1'b1;
      end
    end

    if (hdr_beat) begin
      for (int l = 0; l < NB; l++) begin
        off       = int'(base) + l;
        lane_byte = rx_data[BPCLK-1-8*l -: 8];
        if (off < 6) begin
          if (lane_byte != PAUSE_DA[47-8*off -: 8]) da_pause_d = 1'b0;
          if (lane_byte != mac_addr[47-8*off -: 8]) da_mac_d   = 1'b0;
        end else if (off >= 12 && off <= 15) begin
          if (lane_byte != hdr_exp(off)) hdr_bad = 1'b1;
        end else if (off == 16) begin
          quanta_d[15:8] = lane_byte;
        end else if (off == 17) begin
          quanta_d[7:0] = lane_byte;
          got_quanta    = 1'b1;
        end
      end
      if (!da_pause_d && !da_mac_d) hdr_bad = 1'b1;

      byte_off_d = off_sat_add(base);
      if (rx_eop) begin
        // Frame ends on this beat: only a complete, matching header reports.
        state_d = IDLE;
        emit    = !hdr_bad && got_quanta && !rx_err;
      end else if (hdr_bad) begin
        state_d = DROP;
      end else if (got_quanta) begin
        state_d = WAIT;
      end else begin
        state_d = HDR;
      end
    end else if (rx_valid && state_q != IDLE) begin
      byte_off_d = off_sat_add(byte_off_q);
      if (rx_eop) begin
        state_d = IDLE;
        emit    = (state_q == WAIT) && !rx_err;
      end
    end
  end

  // State, capture and output registers; pulse lands one cycle after eop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_off_q <= 5'd0;
      da_pause_q <= 1'b0;
      da_mac_q   <= 1'b0;
      quanta_q   <= 16'h0000;
      pulse_q    <= 1'b0;
      ptime_q    <= 16'h0000;
      cnt_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      byte_off_q <= byte_off_d;
      da_pause_q <= da_pause_d;
      da_mac_q   <= da_mac_d;
      quanta_q   <= quanta_d;
      pulse_q    <= emit && pause_en;
      if (emit && pause_en) ptime_q <= quanta_d;
      if (emit) cnt_q <= cnt_sat_inc(cnt_q);
    end
  end

  assign pause_time_valid = pulse_q;
  assign pause_time       = ptime_q;
  assign pause_frm_cnt    = cnt_q;

endmodule

// File: tb/tb_peg_l2_mac_pause_parser.sv
// Testbench for peg_l2_mac_pause_parser: three instances (64/32/8-bit buses)
// share one byte-lane driver; a frame-level model pushes expected pulses to a
// scoreboard queue which a negedge monitor pops when a pulse appears.
module tb_peg_l2_mac_pause_parser;

  localparam logic [47:0] PDA = 48'h0180C2000001;
  localparam logic [47:0] MAC = 48'h001122334455;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        pause_en;
  logic [47:0] mac_addr;
  logic        drv_valid, drv_sop, drv_eop, drv_err;
  logic [63:0] dbus;
  int          sel;
  logic [2:0]  v;
  logic [2:0]  pv;
  logic [15:0] pt [3];
  logic [15:0] pc [3];

  assign v[0] = drv_valid && (sel == 0);
  assign v[1] = drv_valid && (sel == 1);
  assign v[2] = drv_valid && (sel == 2);

  peg_l2_mac_pause_parser #(.BPCLK(64), .PAUSE_DA(PDA)) u64 (
    .clk(clk), .rst(rst), .pause_en(pause_en), .mac_addr(mac_addr),
    .rx_valid(v[0]), .rx_sop(drv_sop), .rx_eop(drv_eop), .rx_err(drv_err),
    .rx_data(dbus),
    .pause_time_valid(pv[0]), .pause_time(pt[0]), .pause_frm_cnt(pc[0]));

  peg_l2_mac_pause_parser #(.BPCLK(32), .PAUSE_DA(PDA)) u32 (
    .clk(clk), .rst(rst), .pause_en(pause_en), .mac_addr(mac_addr),
    .rx_valid(v[1]), .rx_sop(drv_sop), .rx_eop(drv_eop), .rx_err(drv_err),
    .rx_data(dbus[63:32]),
    .pause_time_valid(pv[1]), .pause_time(pt[1]), .pause_frm_cnt(pc[1]));

  peg_l2_mac_pause_parser #(.BPCLK(8), .PAUSE_DA(PDA)) u8 (
    .clk(clk), .rst(rst), .pause_en(pause_en), .mac_addr(mac_addr),
    .rx_valid(v[2]), .rx_sop(drv_sop), .rx_eop(drv_eop), .rx_err(drv_err),
    .rx_data(dbus[63:56]),
    .pause_time_valid(pv[2]), .pause_time(pt[2]), .pause_frm_cnt(pc[2]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          idx;
    logic [15:0] q;
    int          c;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [7:0]  frm[$];
  logic [15:0] cnt_m [3];
  logic [15:0] pt_m [3];
  logic [47:0] f_da;
  logic [15:0] f_et, f_op, f_q;
  int          f_len;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest expected entry.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (pv[i] === 1'b1) begin
        chk("pulse_expected", 32'(sbq.size() > 0), 32'd1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("pulse_inst", 32'(i), 32'(e.idx));
          chk("pulse_time", 32'(pt[i]), 32'(e.q));
          chk("pulse_cycle", 32'(cyc), 32'(e.c));
        end
      end
    end
  end

  task automatic build(input logic [47:0] da, input logic [15:0] et,
                       input logic [15:0] op, input logic [15:0] q, input int len);
    frm.delete();
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      if (i < 6)        b = da[47-8*i -: 8];
      else if (i < 12)  b = 8'(8'hA0 + i);
      else if (i == 12) b = et[15:8];
      else if (i == 13) b = et[7:0];
      else if (i == 14) b = op[15:8];
      else if (i == 15) b = op[7:0];
      else if (i == 16) b = q[15:8];
      else if (i == 17) b = q[7:0];
      else              b = 8'(i * 7);
      frm.push_back(b);
    end
    f_da = da; f_et = et; f_op = op; f_q = q; f_len = len;
  endtask

  // stop < 0 sends the whole frame with eop; otherwise only stop bytes, no eop.
  task automatic send(input int s, input logic err, input int stop,
                      input int gap_beat, input int gap_len);
    int nb, n, nbeats;
    nb     = (s == 0) ? 8 : (s == 1) ? 4 : 1;
    n      = (stop < 0) ? frm.size() : stop;
    nbeats = (n + nb - 1) / nb;
    sel    = s;
    for (int bt = 0; bt < nbeats; bt++) begin
      if (bt == gap_beat) begin
        repeat (gap_len) begin
          @(negedge clk);
          drv_valid = 1'b0; drv_sop = 1'b1; drv_eop = 1'b1; dbus = 64'hDEAD_BEEF_0BAD_F00D;
        end
      end
      @(negedge clk);
      drv_valid = 1'b1;
      drv_sop   = (bt == 0);
      drv_eop   = (bt == nbeats - 1) && (stop < 0);
      drv_err   = err && drv_eop;
      dbus      = '0;
      for (int l = 0; l < nb; l++)
        if (bt * nb + l < n) dbus[63-8*l -: 8] = frm[bt * nb + l];
      if (drv_eop && f_len >= 18 && (f_da == PDA || f_da == mac_addr) &&
          f_et == 16'h8808 && f_op == 16'h0001 && !err) begin
        cnt_m[s] = (cnt_m[s] == 16'hFFFF) ? 16'hFFFF : cnt_m[s] + 16'd1;
        if (pause_en) begin
          sbq.push_back('{idx: s, q: f_q, c: cyc + 1});
          pt_m[s] = f_q;
        end
      end
    end
    @(negedge clk);
    drv_valid = 1'b0; drv_sop = 1'b0; drv_eop = 1'b0; drv_err = 1'b0;
  endtask

  task automatic settle(input int s);
    repeat (3) @(negedge clk);
    chk("no_missing_pulse", 32'(sbq.size()), 32'd0);
    chk("frm_cnt", 32'(pc[s]), 32'(cnt_m[s]));
    chk("pause_time_hold", 32'(pt[s]), 32'(pt_m[s]));
    chk("pulse_low", 32'(pv[s]), 32'd0);
  endtask

  initial begin
    rst = 1'b1; pause_en = 1'b1; mac_addr = MAC;
    drv_valid = 1'b0; drv_sop = 1'b0; drv_eop = 1'b0; drv_err = 1'b0;
    dbus = '0; sel = 0;
    for (int i = 0; i < 3; i++) begin cnt_m[i] = 16'h0; pt_m[i] = 16'h0; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_valid", 32'(pv[i]), 32'd0);
      chk("reset_time", 32'(pt[i]), 32'd0);
      chk("reset_cnt", 32'(pc[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Basic PAUSE, then rejected variants.
    build(PDA, 16'h8808, 16'h0001, 16'h1234, 64); send(0, 1'b0, -1, -1, 0); settle(0);
    send(0, 1'b1, -1, -1, 0); settle(0);
    build(PDA, 16'h8808, 16'h0002, 16'h5555, 64); send(0, 1'b0, -1, -1, 0); settle(0);
    build(PDA, 16'h0800, 16'h0001, 16'h5555, 64); send(0, 1'b0, -1, -1, 0); settle(0);

    // Station address as DA, and a near-miss address.
    build(MAC, 16'h8808, 16'h0001, 16'hFFFF, 64); send(0, 1'b0, -1, -1, 0); settle(0);
    build(48'h001122334456, 16'h8808, 16'h0001, 16'h4321, 64); send(0, 1'b0, -1, -1, 0); settle(0);

    // Reporting disabled still counts; runt; restart on a mid-header sop.
    pause_en = 1'b0;
    build(PDA, 16'h8808, 16'h0001, 16'h0777, 64); send(0, 1'b0, -1, -1, 0); settle(0);
    pause_en = 1'b1;
    build(PDA, 16'h8808, 16'h0001, 16'h0999, 16); send(0, 1'b0, -1, -1, 0); settle(0);
    build(PDA, 16'h8808, 16'h0001, 16'h0BBB, 64); send(0, 1'b0, 10, -1, 0);
    build(PDA, 16'h8808, 16'h0001, 16'h0ACE, 64); send(0, 1'b0, -1, -1, 0); settle(0);

    // Back-to-back frames with idle gaps inside the header; resume quanta 0.
    build(PDA, 16'h8808, 16'h0001, 16'h0010, 64); send(0, 1'b0, -1, 1, 2);
    build(PDA, 16'h8808, 16'h0001, 16'h0000, 64); send(0, 1'b0, -1, 2, 3); settle(0);

    // Reset while waiting for eop: everything clears and no pulse follows.
    build(PDA, 16'h8808, 16'h0001, 16'h0F0F, 64); send(0, 1'b0, 24, -1, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_valid", 32'(pv[0]), 32'd0);
    chk("midrst_time", 32'(pt[0]), 32'd0);
    chk("midrst_cnt", 32'(pc[0]), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin cnt_m[i] = 16'h0; pt_m[i] = 16'h0; end
    @(negedge clk);
    drv_valid = 1'b1; drv_sop = 1'b0; drv_eop = 1'b1; dbus = '0; sel = 0;
    @(negedge clk);
    drv_valid = 1'b0; drv_eop = 1'b0;
    settle(0);

    // Narrower buses.
    for (int s = 1; s < 3; s++) begin
      build(PDA, 16'h8808, 16'h0001, 16'h1234, 64); send(s, 1'b0, -1, 3, 2); settle(s);
      build(MAC, 16'h8808, 16'h0001, 16'hFFFF, 64); send(s, 1'b0, -1, -1, 0); settle(s);
      build(48'h001122334456, 16'h8808, 16'h0001, 16'h2222, 64); send(s, 1'b0, -1, -1, 0); settle(s);
    end

    // Counter saturation.
    @(negedge clk);
    force u64.cnt_q = 16'hFFFE;
    @(negedge clk);
    release u64.cnt_q;
    cnt_m[0] = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      build(PDA, 16'h8808, 16'h0001, 16'(16'h0100 + k), 18); send(0, 1'b0, -1, -1, 0); settle(0);
    end
    chk("cnt_saturated", 32'(pc[0]), 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
